// File: rtl/jogo_seq_pkg.sv
// Shared definitions for the sequence-memory game: state codes, LFSR taps, seed fallback.
package jogo_seq_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    GERA        = 4'h1,
    MOSTRA      = 4'h2,
    APAGA       = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROX_JOGADA = 4'h7,
    PROX_RODADA = 4'h8,
    GANHOU      = 4'hA,
    PERDEU      = 4'hE
  } estado_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] SEMENTE_PADRAO = 16'h0001;

  function automatic logic [15:0] lfsr_proximo(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gerador_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load and step; exposes the low W_SAIDA bits.
module gerador_lfsr
  import jogo_seq_pkg::*;
#(
  parameter int W_SAIDA = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic               avanca,
  input  logic [15:0]        semente,
  output logic [W_SAIDA-1:0] saida
);

  logic [15:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       lfsr <= SEMENTE_PADRAO;
    else if (carrega) lfsr <= semente;
    else if (avanca)  lfsr <= lfsr_proximo(lfsr);
  end

  assign saida = lfsr[W_SAIDA-1:0];

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game engine: generates, replays and checks a growing random sequence.
// Optional press timeout enabled by defining JOGO_SEQ_TIMEOUT_EN.
module jogo_sequencia_param
  import jogo_seq_pkg::*;
#(
  parameter  int N_BOTOES       = 4,
  parameter  int PROF_MAX       = 16,
  parameter  int LED_CICLOS     = 500,
  parameter  int TIMEOUT_CICLOS = 3000,
  localparam int W              = $clog2(N_BOTOES),
  localparam int RW             = $clog2(PROF_MAX + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic [3:0]          db_estado,
  output logic [RW-1:0]       db_rodada,
  output logic [W-1:0]        db_jogada
);

  localparam int AW = (PROF_MAX > 1) ? $clog2(PROF_MAX) : 1;
  localparam int CW = $clog2(LED_CICLOS + 1);

  estado_t             estado;
  logic [15:0]         cnt_livre;
  logic [W-1:0]        seq [PROF_MAX];
  logic [RW-1:0]       rodada;
  logic [RW-1:0]       idx;
  logic [AW-1:0]       idx_a;
  logic [CW-1:0]       ciclo;
  logic [N_BOTOES-1:0] botoes_ant;
  logic [N_BOTOES-1:0] press_reg;
  logic [W-1:0]        jogada_reg;
  logic                invalido;
  logic                jogada;
  logic                timeout_ev;
  logic                inicio;
  logic                fim_led;
  logic                ultimo_idx;
  logic [15:0]         semente;
  logic [W-1:0]        lfsr_sym;
  logic [W-1:0]        menor;
  logic                multiplo;

  assign idx_a      = idx[AW-1:0];
  assign jogada     = (|botoes) && !(|botoes_ant);
  assign inicio     = jogar && (estado == INICIAL || estado == GANHOU || estado == PERDEU);
  assign fim_led    = (ciclo == CW'(LED_CICLOS - 1));
  assign ultimo_idx = (idx == rodada - RW'(1));
  assign semente    = (cnt_livre == '0) ? SEMENTE_PADRAO : cnt_livre;

  gerador_lfsr #(.W_SAIDA(W)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .carrega (inicio),
    .avanca  (estado == GERA),
    .semente (semente),
    .saida   (lfsr_sym)
  );

`ifdef JOGO_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] timer;

  // Cleared outside ESPERA, so every entry into ESPERA starts a fresh press window
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 timer <= '0;
    else if (estado == ESPERA)  timer <= timer + TW'(1);
    else                        timer <= '0;
  end

  assign timeout_ev = (estado == ESPERA) && (timer == TW'(TIMEOUT_CICLOS - 1)) && !jogada;
`else
  assign timeout_ev = 1'b0;
`endif

  // Lowest pressed button, and whether more than one is down
  always_comb begin
    logic found;
    menor = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_BOTOES; i++) begin
      if (press_reg[i] && !found) begin
        menor = W'(i);
        found = 1'b1;
      end
    end
    multiplo = (press_reg & (press_reg - N_BOTOES'(1))) != '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      cnt_livre  <= '0;
      rodada     <= '0;
      idx        <= '0;
      ciclo      <= '0;
      botoes_ant <= '0;
      press_reg  <= '0;
      jogada_reg <= '0;
      invalido   <= 1'b0;
      for (int unsigned i = 0; i < PROF_MAX; i++) seq[i] <= '0;
    end else begin
      cnt_livre  <= cnt_livre + 16'd1;
      botoes_ant <= botoes;
      case (estado)
        INICIAL, GANHOU, PERDEU: begin
          if (jogar) begin
            estado <= GERA;
            rodada <= RW'(1);
            idx    <= '0;
          end
        end
        GERA: begin
          seq[idx_a] <= lfsr_sym;
          if (idx == RW'(PROF_MAX - 1)) begin
            idx    <= '0;
            ciclo  <= '0;
            estado <= MOSTRA;
          end else begin
            idx <= idx + RW'(1);
          end
        end
        MOSTRA: begin
          if (fim_led) begin
            ciclo  <= '0;
            estado <= APAGA;
          end else begin
            ciclo <= ciclo + CW'(1);
          end
        end
        APAGA: begin
          if (fim_led) begin
            ciclo <= '0;
            if (ultimo_idx) begin
              idx    <= '0;
              estado <= ESPERA;
            end else begin
              idx    <= idx + RW'(1);
              estado <= MOSTRA;
            end
          end else begin
            ciclo <= ciclo + CW'(1);
          end
        end
        ESPERA: begin
          if (jogada) begin
            press_reg <= botoes;
            estado    <= REGISTRA;
          end else if (timeout_ev) begin
            estado <= PERDEU;
          end
        end
        REGISTRA: begin
          jogada_reg <= menor;
          invalido   <= multiplo;
          estado     <= COMPARA;
        end
        COMPARA: begin
          if (invalido || jogada_reg != seq[idx_a]) estado <= PERDEU;
          else if (ultimo_idx)                      estado <= PROX_RODADA;
          else                                      estado <= PROX_JOGADA;
        end
        PROX_JOGADA: begin
          idx    <= idx + RW'(1);
          estado <= ESPERA;
        end
        PROX_RODADA: begin
          if (rodada == RW'(PROF_MAX)) begin
            estado <= GANHOU;
          end else begin
            rodada <= rodada + RW'(1);
            idx    <= '0;
            ciclo  <= '0;
            estado <= MOSTRA;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    if (estado == MOSTRA) leds[seq[idx_a]] = 1'b1;
  end

  assign pronto     = (estado == GANHOU) || (estado == PERDEU);
  assign ganhou     = (estado == GANHOU);
  assign perdeu     = (estado == PERDEU);
  assign db_timeout = timeout_ev;
  assign db_estado  = estado;
  assign db_rodada  = rodada;
  assign db_jogada  = jogada_reg;

endmodule
